// File: rtl/alu_flag_wb_stage.sv
// ALU writeback stage: registers result/dest for the register file, maintains the PSR, evaluates branch conditions.
// Latency: 1 cycle from accept to out_valid; cond_true is combinational (next-PSR when FLAG_BYPASS=1).
// Backpressure: single-entry slot; in_ready = !out_valid || out_ready, so it streams at full rate while out_ready=1.
module alu_flag_wb_stage #(
    parameter bit FLAG_BYPASS = 1'b1,
    parameter int DEST_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_control,
    input  logic [15:0]       result_in,
    input  logic              c_in,
    input  logic              l_in,
    input  logic              f_in,
    input  logic              z_in,
    input  logic              n_in,
    input  logic [DEST_W-1:0] dest_in,
    input  logic              wb_en_in,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [15:0]       wb_data,
    output logic [DEST_W-1:0] wb_dest,
    output logic              wb_en,
    input  logic              psr_load,
    input  logic [4:0]        psr_load_data,
    output logic [4:0]        psr,
    input  logic [3:0]        cond_code,
    output logic              cond_true
);

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b1000;

    // PSR bit positions within {N,Z,F,L,C}
    localparam int PC = 0;
    localparam int PL = 1;
    localparam int PF = 2;
    localparam int PZ = 3;
    localparam int PN = 4;

    typedef struct packed {
        logic [15:0]       data;
        logic [DEST_W-1:0] dest;
        logic              en;
    } wb_ent_t;

    wb_ent_t    ent_q;
    logic       accept;
    logic [4:0] psr_nxt;
    logic [4:0] psr_eval;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    assign wb_data = ent_q.data;
    assign wb_dest = ent_q.dest;
    // Not gated by flush: the register file kills the write itself.
    assign wb_en   = out_valid && ent_q.en;

    always_comb begin
        psr_nxt = psr;
        if (accept) begin
            if (alu_control == OP_ADD || alu_control == OP_SUB) begin
                psr_nxt[PC] = c_in;
                psr_nxt[PF] = f_in;
            end else if (alu_control == OP_CMP) begin
                psr_nxt[PL] = l_in;
                psr_nxt[PZ] = z_in;
                psr_nxt[PN] = n_in;
            end
        end
        if (psr_load) begin
            psr_nxt = psr_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            ent_q     <= '0;
            psr       <= '0;
        end else begin
            psr <= psr_nxt;
            if (accept) begin
                ent_q.data <= result_in;
                ent_q.dest <= dest_in;
                ent_q.en   <= wb_en_in && (alu_control != OP_NOP) && (alu_control != OP_CMP);
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign psr_eval = FLAG_BYPASS ? psr_nxt : psr;

    always_comb begin
        cond_true = 1'b0;
        case (cond_code)
            4'b0000: cond_true = psr_eval[PZ];
            4'b0001: cond_true = !psr_eval[PZ];
            4'b0010: cond_true = psr_eval[PC];
            4'b0011: cond_true = !psr_eval[PC];
            4'b0100: cond_true = psr_eval[PL];
            4'b0101: cond_true = !psr_eval[PL];
            4'b0110: cond_true = psr_eval[PF];
            4'b0111: cond_true = !psr_eval[PF];
            4'b1000: cond_true = psr_eval[PN];
            4'b1001: cond_true = !psr_eval[PN];
            4'b1010: cond_true = psr_eval[PL] || psr_eval[PZ];
            4'b1011: cond_true = !psr_eval[PL] && !psr_eval[PZ];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: doc/alu_flag_wb_stage.md
Name: alu_flag_wb_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Registers the ALU result and destination for register-file writeback.
- Maintains the processor status register (PSR: C, L, F, Z, N), updating it selectively by ALU opcode.
- Evaluates 4-bit branch/jump condition codes against the PSR for the fetch/branch unit.
- Valid/ready handshake on both sides; supports flush and direct PSR load.

Parameters:
- FLAG_BYPASS, 1: when 1, cond_true reflects a flag update accepted in the same cycle (next-PSR). When 0, cond_true uses the registered PSR only.
- DEST_W, 4: register-file address width.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  ALU output valid
- in_ready  output  1  stage can accept
- alu_control  input  4  opcode the ALU executed (0001 SUB, 0010 CMP, 1000 ADD, 0000 NOP, others logic/move)
- result_in  input  16  ALU result
- c_in, l_in, f_in, z_in, n_in  input  1 each  ALU flags
- dest_in  input  DEST_W  destination register
- wb_en_in  input  1  instruction writes a register
- flush  input  1  kill in-flight and incoming entries
- out_ready  input  1  register file accepts writeback
- out_valid  output  1  writeback entry held
- wb_data  output  16  registered result
- wb_dest  output  DEST_W  registered destination
- wb_en  output  1  out_valid AND registered write enable
- psr_load  input  1  direct PSR write (e.g. LPR)
- psr_load_data  input  5  {N,Z,F,L,C}
- psr  output  5  {N,Z,F,L,C}
- cond_code  input  4  condition to evaluate
- cond_true  output  1  condition result, combinational

Behaviour:
- Reset (reset==0 at a clk edge):
  - out_valid=0, wb_data=0, wb_dest=0, psr=0.
  - The reset condition wins over everything, including mid-handshake.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept = in_valid && in_ready && !flush.
  - On accept, wb_data, wb_dest and the write enable are registered and out_valid=1 next cycle. Latency is 1 cycle.
  - If out_valid && out_ready && !accept, out_valid clears next cycle.
  - Back-to-back accepts while out_ready=1 give full throughput.
- Writeback suppression: the registered write enable = wb_en_in && alu_control not in {0000, 0010}. CMP and NOP never write a register but still occupy the slot.
- Flush:
  - The incoming beat is not accepted and out_valid=0 next cycle.
  - The PSR is not updated by the flushed beat.
  - The held entry is dropped even if out_ready=1 in that cycle, and wb_en is still asserted combinationally that cycle; the register file treats flush as its own kill.
- PSR update, only on accept:
  - ADD (1000) or SUB (0001): C<=c_in, F<=f_in. L, Z, N are held.
  - CMP (0010): L<=l_in, Z<=z_in, N<=n_in. C, F are held.
  - All other opcodes: PSR held.
  - psr_load=1 writes all 5 bits from psr_load_data and overrides a same-cycle ALU update. psr_load is honoured regardless of flush/handshake.
- Condition evaluation uses P = next-PSR if FLAG_BYPASS else psr:
  - 0000 EQ Z
  - 0001 NE !Z
  - 0010 CS C
  - 0011 CC !C
  - 0100 LT L
  - 0101 GE !L
  - 0110 FS F
  - 0111 FC !F
  - 1000 MI N
  - 1001 PL !N
  - 1010 LE L|Z
  - 1011 GT !L&!Z
  - 1110 UC 1
  - 1111 NV 0
  - 1100, 1101 reserved, always 0
- Widths: no arithmetic in this stage; data passes unmodified.

Test Plan:
- Reset: hold reset=0 two cycles with in_valid=1 -> out_valid=0, psr=5'b00000, wb_data=0. Release; ADD with result_in=16'h0005, c_in=0, dest 3, wb_en_in=1 -> next cycle out_valid=1, wb_data=16'h0005, wb_dest=3, wb_en=1.
- Selective flags:
  - CMP with l_in=1, n_in=1, z_in=0 -> psr=5'b10010, wb_en=0.
  - Then SUB with c_in=1, f_in=1 -> psr=5'b10111.
  - Then AND with all flag inputs 0 -> psr unchanged.
- Backpressure: out_ready=0 with an entry held -> in_ready=0, a second ADD is not accepted and PSR is unchanged. out_ready=1 -> second entry appears on the following cycle, no loss or duplication.
- Flush: in_valid=1 ADD c_in=1 with flush=1 -> out_valid=0 next cycle, psr.C unchanged. Also flush while an entry is held -> out_valid=0 next cycle.
- psr_load vs ALU: same-cycle CMP (z_in=1) and psr_load_data=5'b00001 -> psr=5'b00001.
- Conditions with FLAG_BYPASS=1: CMP z_in=1 being accepted, cond_code=EQ -> cond_true=1 in the same cycle. With FLAG_BYPASS=0 -> cond_true=0 that cycle and 1 the next. Sweep all 16 codes for psr=5'b01010: EQ=1, LT=1, LE=1, GT=0, UC=1, NV=0, 1100=0.
